cpu_mem_loader: RTL and testbench

CPU_MEM_LOADER -- requirements
Module: cpu_mem_loader

---
 rtl/cpu_mem_loader.sv | 127 ++++++++++++
 tb/tb_cpu_mem_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader
// Loads a program byte-serially into a 256x16 instruction memory while the
// CPU is held in reset, then releases the CPU and serves its instruction
// fetches and data-memory accesses.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        synchronous active-high reset
//   ld_start     one-cycle pulse starting a load (accepted in IDLE or RUN)
//   ld_count     word count sampled with ld_start, 0 means 256
//   ld_data      load byte, high byte first then low byte
//   ld_valid     ld_data is valid
//   ld_ready     loader accepts a byte this cycle
//   ld_done      load complete, CPU running (registered)
//   cpu_reset    CPU reset, high except while running (registered)
//   PC / IR      instruction fetch address / combinational instruction word
//   Address_out  data address from the CPU
//   Data_out     write data from the CPU
//   MW           data memory write strobe (honoured only while running)
//   Data_in      combinational read data for Address_out
module cpu_mem_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_start,
   input  logic [7:0]  ld_count,
   input  logic [7:0]  ld_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   output logic        ld_done,
   output logic        cpu_reset,
   input  logic [7:0]  PC,
   output logic [15:0] IR,
   input  logic [7:0]  Address_out,
   input  logic [7:0]  Data_out,
   input  logic        MW,
   output logic [7:0]  Data_in
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_HI = 2'd1,
      LOAD_LO = 2'd2,
      RUN     = 2'd3
   } state_t;

   state_t      state, next_state;
   logic [7:0]  load_addr, next_load_addr;
   logic [8:0]  remaining, next_remaining;
   logic [7:0]  hi_byte, next_hi_byte;
   logic        imem_we;
   logic        transfer;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];

   assign transfer = ld_valid && ld_ready;

   // Next-state and datapath control. A start pulse (from IDLE or RUN)
   // rearms the address and the 9-bit word counter so that a count of 0
   // loads the full 256 words.
   always_comb begin
      next_state     = state;
      next_load_addr = load_addr;
      next_remaining = remaining;
      next_hi_byte   = hi_byte;
      imem_we        = 1'b0;
      ld_ready       = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (ld_start) begin
               next_state     = LOAD_HI;
               next_load_addr = 8'd0;
               next_remaining = (ld_count == 8'd0) ? 9'd256 : {1'b0, ld_count};
            end
         end
         LOAD_HI: begin
            ld_ready = 1'b1;
            if (transfer) begin
               next_hi_byte = ld_data;
               next_state   = LOAD_LO;
            end
         end
         LOAD_LO: begin
            ld_ready = 1'b1;
            if (transfer) begin
               imem_we        = 1'b1;
               next_load_addr = load_addr + 8'd1;
               next_remaining = remaining - 9'd1;
               next_state     = (remaining == 9'd1) ? RUN : LOAD_HI;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State and loader registers. The status outputs are registered from the
   // next state so they always track the current state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         load_addr <= 8'd0;
         remaining <= 9'd0;
         hi_byte   <= 8'd0;
         cpu_reset <= 1'b1;
         ld_done   <= 1'b0;
      end else begin
         state     <= next_state;
         load_addr <= next_load_addr;
         remaining <= next_remaining;
         hi_byte   <= next_hi_byte;
         cpu_reset <= (next_state != RUN);
         ld_done   <= (next_state == RUN);
      end
   end

   // Memories are never cleared; reset only blocks further writes.
   always_ff @(posedge clk) begin
      if (!reset && imem_we)
         imem[load_addr] <= {hi_byte, ld_data};
      if (!reset && MW && state == RUN)
         dmem[Address_out] <= Data_out;
   end

   assign IR      = imem[PC];
   assign Data_in = dmem[Address_out];

endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader
// Directed testbench for cpu_mem_loader: loads, valid stalls, data memory
// writes in and out of RUN, a full 256-word load, reset abort and restart.
module tb_cpu_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_start;
   logic [7:0]  ld_count;
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_ready;
   logic        ld_done;
   logic        cpu_reset;
   logic [7:0]  PC;
   logic [15:0] IR;
   logic [7:0]  Address_out;
   logic [7:0]  Data_out;
   logic        MW;
   logic [7:0]  Data_in;

   int vectors = 0;
   int miscompares = 0;

   cpu_mem_loader dut (
      .clk(clk),
      .reset(reset),
      .ld_start(ld_start),
      .ld_count(ld_count),
      .ld_data(ld_data),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_done(ld_done),
      .cpu_reset(cpu_reset),
      .PC(PC),
      .IR(IR),
      .Address_out(Address_out),
      .Data_out(Data_out),
      .MW(MW),
      .Data_in(Data_in)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_data  = b;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic start_load(input logic [7:0] cnt);
      ld_start = 1'b1;
      ld_count = cnt;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic check_imem(input string tag, input logic [7:0] addr, input logic [15:0] exp);
      PC = addr;
      #1;
      check(tag, IR, exp);
   endtask

   initial begin
      logic [7:0] idx;
      reset = 1'b1; ld_start = 1'b0; ld_count = 8'd0; ld_data = 8'd0;
      ld_valid = 1'b0; PC = 8'd0; Address_out = 8'd0; Data_out = 8'd0; MW = 1'b0;

      // Reset state
      tick();
      reset = 1'b0;
      check("reset ld_ready", ld_ready, 0);
      check("reset ld_done", ld_done, 0);
      check("reset cpu_reset", cpu_reset, 1);

      // Two-word load with continuous valid
      start_load(8'd2);
      check("load1 ld_ready", ld_ready, 1);
      check("load1 cpu_reset", cpu_reset, 1);
      send_byte(8'h98);
      send_byte(8'h41);
      send_byte(8'h02);
      check("load1 not done after 3", ld_done, 0);
      send_byte(8'h8A);
      check("load1 ld_done", ld_done, 1);
      check("load1 cpu_reset low", cpu_reset, 0);
      check("load1 ld_ready low", ld_ready, 0);
      check_imem("load1 imem0", 8'h00, 16'h9841);
      check_imem("load1 imem1", 8'h01, 16'h028A);

      // Data memory write in RUN
      MW = 1'b1; Address_out = 8'h10; Data_out = 8'h5A;
      tick();
      MW = 1'b0; Data_out = 8'h00;
      #1;
      check("run dmem write", Data_in, 8'h5A);

      // Restart from RUN, then a load with valid stalls and an ignored start
      start_load(8'd2);
      check("restart cpu_reset", cpu_reset, 1);
      check("restart ld_done", ld_done, 0);
      check("restart ld_ready", ld_ready, 1);
      send_byte(8'h12);
      ld_data = 8'hFF;
      tick();
      ld_start = 1'b1; ld_count = 8'd5;
      tick();
      ld_start = 1'b0;
      check("stall ld_ready", ld_ready, 1);
      send_byte(8'h34);
      tick();
      send_byte(8'h56);
      send_byte(8'h78);
      check("stall load ld_done", ld_done, 1);
      check_imem("stall imem0", 8'h00, 16'h1234);
      check_imem("stall imem1", 8'h01, 16'h5678);

      // MW ignored outside RUN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      MW = 1'b1; Address_out = 8'h10; Data_out = 8'hA5;
      tick();
      MW = 1'b0;
      #1;
      check("idle dmem unchanged", Data_in, 8'h5A);

      // Full 256-word load (ld_count = 0)
      start_load(8'd0);
      for (int i = 0; i < 256; i++) begin
         idx = i[7:0];
         send_byte(idx ^ 8'h5A);
         if (i == 255) check("full not done after 511", ld_done, 0);
         send_byte(~idx);
      end
      check("full ld_done", ld_done, 1);
      check("full cpu_reset", cpu_reset, 0);
      for (int i = 0; i < 256; i += 17) begin
         idx = i[7:0];
         check_imem("full imem", idx, {idx ^ 8'h5A, ~idx});
      end
      check_imem("full imem ff", 8'hFF, 16'hA500);

      // Reset after 3 bytes of a 2-word load, with start and valid also high
      start_load(8'd2);
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_byte(8'hEF);
      reset = 1'b1; ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h99;
      tick();
      reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
      check("abort ld_ready", ld_ready, 0);
      check("abort cpu_reset", cpu_reset, 1);
      check("abort ld_done", ld_done, 0);
      check_imem("abort imem0", 8'h00, 16'hABCD);
      check_imem("abort imem1", 8'h01, 16'h5BFE);
      tick();
      check("abort stays idle", ld_ready, 0);

      // Fresh one-word load after abort
      start_load(8'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      check("reload ld_done", ld_done, 1);
      check_imem("reload imem0", 8'h00, 16'h1122);
      check_imem("reload imem1", 8'h01, 16'h5BFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
